mtm_alu_response_decoder: RTL and testbench

Receives the serial response stream produced on the ALU `sout` line, reassembles DATA and ERROR packets, checks CRC and parity, and presents each decoded response as one registered parallel word with a single-cycle valid strobe. It sits directly downstream of the ALU serializer and is used by the bench scoreboard and by any on-chip consumer of ALU results.

---
 rtl/mtm_alu_response_decoder.sv | 150 +++++++++++++++
 tb/tb_mtm_alu_response_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_response_decoder.sv
// mtm_alu_response_decoder: deserializes ALU sout DATA/ERROR packets into registered response words
module mtm_alu_response_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        rsp_valid,
  output logic        rsp_is_err,
  output logic [31:0] C_out,
  output logic [3:0]  flags_out,
  output logic [5:0]  err_flags_out,
  output logic        chk_ok,
  output logic        frame_err
);
  typedef enum logic [2:0] {IDLE, TYPE, DATA, STOP, RESYNC} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        type_q, type_d;
  logic [7:0]  byte_q, byte_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] sh_q, sh_d;
  logic        dv_q, dv_d, df_q, df_d, de_q, de_d, dok_q, dok_d;
  logic [31:0] dc_q, dc_d;
  logic [3:0]  dfl_q, dfl_d;
  logic [5:0]  def_q, def_d;
  logic        vld_q, ferr_q, iserr_q, ok_q;
  logic [31:0] c_q;
  logic [3:0]  fl_q;
  logic [5:0]  ef_q;
  logic        bad, crc_ok;
  function automatic logic [2:0] crc3(input logic [36:0] d);
    logic [2:0] c;
    logic fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction
  assign bad = !sin || (type_q ? (idx_q == 3'd0 ? !byte_q[7] : (idx_q != 3'd4 || byte_q[7])) : idx_q == 3'd4);
  assign crc_ok = crc3({sh_q, 1'b0, byte_q[6:3]}) == byte_q[2:0];
  // state, byte assembly, packet tracking and the decode stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      type_q  <= 1'b0;
      byte_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      dv_q    <= 1'b0;
      df_q    <= 1'b0;
      de_q    <= 1'b0;
      dok_q   <= 1'b0;
      dc_q    <= '0;
      dfl_q   <= '0;
      def_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      dv_q    <= dv_d;
      df_q    <= df_d;
      de_q    <= de_d;
      dok_q   <= dok_d;
      dc_q    <= dc_d;
      dfl_q   <= dfl_d;
      def_q   <= def_d;
    end
  end
  // byte FSM; at the stop bit the byte is classified and the packet either grows, completes or is dropped
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    dv_d    = 1'b0;
    df_d    = 1'b0;
    de_d    = de_q;
    dok_d   = dok_q;
    dc_d    = dc_q;
    dfl_d   = dfl_q;
    def_d   = def_q;
    unique case (state_q)
      IDLE:   state_d = sin ? IDLE : TYPE;
      TYPE: begin
        type_d  = sin;
        cnt_d   = 3'd7;
        state_d = DATA;
      end
      DATA: begin
        byte_d  = {byte_q[6:0], sin};
        cnt_d   = cnt_q - 3'd1;
        state_d = cnt_q == 3'd0 ? STOP : DATA;
      end
      STOP: begin
        state_d = bad ? RESYNC : IDLE;
        if (bad) begin
          df_d  = 1'b1;
          idx_d = '0;
        end else if (type_q) begin
          dv_d  = 1'b1;
          idx_d = '0;
          de_d  = idx_q == 3'd0;
          dok_d = idx_q == 3'd0 ? ~^byte_q : crc_ok;
          def_d = idx_q == 3'd0 ? byte_q[6:1] : def_q;
          dc_d  = idx_q == 3'd0 ? dc_q : sh_q;
          dfl_d = idx_q == 3'd0 ? dfl_q : byte_q[6:3];
        end else begin
          sh_d  = {sh_q[23:0], byte_q};
          idx_d = idx_q + 3'd1;
        end
      end
      RESYNC: state_d = sin ? IDLE : RESYNC;
      default: state_d = IDLE;
    endcase
  end
  // output register: presents the decode stage one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      iserr_q <= 1'b0;
      ok_q    <= 1'b0;
      c_q     <= '0;
      fl_q    <= '0;
      ef_q    <= '0;
    end else begin
      vld_q   <= dv_q;
      ferr_q  <= df_q;
      iserr_q <= de_q;
      ok_q    <= dok_q;
      c_q     <= dc_q;
      fl_q    <= dfl_q;
      ef_q    <= def_q;
    end
  end
  assign rsp_valid     = vld_q;
  assign frame_err     = ferr_q;
  assign rsp_is_err    = iserr_q;
  assign chk_ok        = ok_q;
  assign C_out         = c_q;
  assign flags_out     = fl_q;
  assign err_flags_out = ef_q;
endmodule

// File: tb/tb_mtm_alu_response_decoder.sv
// tb_mtm_alu_response_decoder: serial packet driver with scoreboard of expected response pulses
module tb_mtm_alu_response_decoder;
  logic        clk = 1'b0, rst = 1'b1, sin = 1'b1;
  logic        rsp_valid, rsp_is_err, chk_ok, frame_err;
  logic [31:0] C_out;
  logic [3:0]  flags_out;
  logic [5:0]  err_flags_out;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {
    bit          ferr;
    bit          is_err;
    logic [31:0] c;
    logic [3:0]  fl;
    logic [5:0]  ef;
    bit          ok;
    int          at;
  } exp_t;
  typedef struct {
    bit          is_err;
    logic [31:0] c;
    logic [3:0]  fl;
    logic [2:0]  flip;
    logic [7:0]  p;
    bit          exp_ok;
  } vec_t;
  exp_t sbq[$];
  vec_t tbl[7];
  bit          m_err = 0, m_ok = 0;
  logic [31:0] m_c = '0;
  logic [3:0]  m_fl = '0;
  logic [5:0]  m_ef = '0;
  mtm_alu_response_decoder dut (
    .clk(clk), .rst(rst), .sin(sin), .rsp_valid(rsp_valid), .rsp_is_err(rsp_is_err),
    .C_out(C_out), .flags_out(flags_out), .err_flags_out(err_flags_out),
    .chk_ok(chk_ok), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at cyc %0d", n, a, e, cyc);
    end
  endtask
  function automatic logic [2:0] crc_model(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction
  task automatic push(input bit ferr, input int at);
    exp_t e;
    e.ferr = ferr; e.is_err = m_err; e.c = m_c; e.fl = m_fl; e.ef = m_ef; e.ok = m_ok; e.at = at;
    sbq.push_back(e);
  endtask
  task automatic bitx(input logic b);
    @(negedge clk);
    sin = b;
  endtask
  task automatic idle(input int n);
    repeat (n) bitx(1'b1);
  endtask
  task automatic send_byte(input logic t, input logic [7:0] p, input logic sb, output int st);
    bitx(1'b0);
    st = cyc;
    bitx(t);
    for (int i = 7; i >= 0; i--) bitx(p[i]);
    bitx(sb);
  endtask
  task automatic send_data(input logic [31:0] c, input logic [3:0] f, input logic [2:0] flip, input bit ok);
    int st, s2;
    logic [2:0] cr;
    cr = crc_model(c, f) ^ flip;
    send_byte(1'b0, c[31:24], 1'b1, st);
    m_err = 0; m_c = c; m_fl = f; m_ok = ok;
    push(0, st + 56);
    send_byte(1'b0, c[23:16], 1'b1, s2);
    send_byte(1'b0, c[15:8], 1'b1, s2);
    send_byte(1'b0, c[7:0], 1'b1, s2);
    send_byte(1'b1, {1'b0, f, cr}, 1'b1, s2);
  endtask
  task automatic send_err(input logic [7:0] p, input bit ok);
    int st;
    send_byte(1'b1, p, 1'b1, st);
    m_err = 1; m_ef = p[6:1]; m_ok = ok;
    push(0, st + 12);
  endtask
  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sbq.size(), 0);
    idle(4);
  endtask
  task automatic chk_zero();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_iserr", rsp_is_err, 0);
    chk("rst_C", C_out, 0);
    chk("rst_flags", flags_out, 0);
    chk("rst_eflags", err_flags_out, 0);
    chk("rst_ok", chk_ok, 0);
  endtask
  always @(negedge clk) begin
    if (!rst && (rsp_valid || frame_err)) begin
      chk("exclusive", rsp_valid & frame_err, 0);
      if (sbq.size() == 0) chk("unexpected_pulse", {rsp_valid, frame_err}, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("kind_ferr", frame_err, e.ferr);
        chk("latency", cyc, e.at);
        chk("is_err", rsp_is_err, e.is_err);
        chk("C_out", C_out, e.c);
        chk("flags", flags_out, e.fl);
        chk("err_flags", err_flags_out, e.ef);
        chk("chk_ok", chk_ok, e.ok);
      end
    end
  end
  initial begin
    int st;
    tbl[0] = '{0, 32'h0000_0001, 4'b0000, 3'b000, 8'h00, 1};
    tbl[1] = '{1, 32'h0,         4'b0000, 3'b000, 8'hC9, 1};
    tbl[2] = '{1, 32'h0,         4'b0000, 3'b000, 8'hC8, 0};
    tbl[3] = '{0, 32'hFFFF_FFFF, 4'b1001, 3'b001, 8'h00, 0};
    tbl[4] = '{0, 32'h1234_5678, 4'b0110, 3'b000, 8'h00, 1};
    tbl[5] = '{1, 32'h0,         4'b0000, 3'b000, 8'h81, 1};
    tbl[6] = '{0, 32'hA5A5_0F0F, 4'b1111, 3'b000, 8'h00, 1};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero();
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].is_err) send_err(tbl[i].p, tbl[i].exp_ok);
      else send_data(tbl[i].c, tbl[i].fl, tbl[i].flip, tbl[i].exp_ok);
      idle(2);
    end
    drain();
    send_byte(1'b0, 8'h11, 1'b1, st);
    send_byte(1'b0, 8'h22, 1'b1, st);
    send_byte(1'b0, 8'h33, 1'b0, st);
    push(1, st + 12);
    bitx(1'b0);
    repeat (15) bitx(1'b0);
    idle(3);
    drain();
    send_data(32'hDEAD_BEEF, 4'b0101, 3'b000, 1);
    drain();
    send_byte(1'b0, 8'h44, 1'b1, st);
    send_byte(1'b0, 8'h55, 1'b1, st);
    send_byte(1'b1, 8'h00, 1'b1, st);
    push(1, st + 12);
    idle(3);
    drain();
    send_err(8'hC9, 1);
    drain();
    send_data(32'h8000_0000, 4'b1010, 3'b000, 1);
    send_err(8'hFF, 1);
    drain();
    send_byte(1'b0, 8'h66, 1'b1, st);
    send_byte(1'b0, 8'h77, 1'b1, st);
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_err = 0; m_ok = 0; m_c = '0; m_fl = '0; m_ef = '0;
    @(negedge clk);
    chk_zero();
    idle(20);
    send_err(8'hC8, 0);
    drain();
    send_data(32'h0000_0001, 4'b0000, 3'b000, 1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
